// File: rtl/lab5_pkg.sv
// Shared constants and FSM state type for the product binary-to-BCD converter.
package lab5_pkg;

    localparam int PROD_W_DEFAULT = 16;
    localparam int NDIG_DEFAULT   = 5;
    localparam int BCD_CNT_W      = $clog2(PROD_W_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd_conv.sv
// Sequential signed-product to BCD converter, one double-dabble step per clock.
// Optional leading-zero mask output enabled by defining PROD_BCD_BLANK_EN.
module product_bcd_conv
    import lab5_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int NDIG   = NDIG_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic signed [PROD_W-1:0] Prod,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Neg,
    output logic [NDIG*4-1:0]        Bcd
`ifdef PROD_BCD_BLANK_EN
    ,
    output logic [NDIG-1:0]          Blank
`endif
);

    localparam int CNT_W = $clog2(PROD_W);
    localparam int BCD_W = NDIG * 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROD_W - 1);

    bcd_state_t        state, state_nxt;
    logic              start_q;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] mag;
    logic [BCD_W-1:0]  acc, acc_adj, acc_shl;
    logic              neg_i;
    logic              launch, last;

    // Start edges arriving mid-conversion are dropped, not queued.
    assign launch = Start & ~start_q & (state != SHIFT);
    assign last   = (state == SHIFT) && (cnt == LAST_CNT);

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (acc[4*g +: 4]),
            .fixed (acc_adj[4*g +: 4])
        );
    end

    assign acc_shl = {acc_adj[BCD_W-2:0], mag[PROD_W-1]};

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (launch) state_nxt = SHIFT;
            SHIFT:      if (cnt == LAST_CNT) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

`ifdef PROD_BCD_BLANK_EN
    function automatic logic [NDIG-1:0] blank_mask(input logic [BCD_W-1:0] b);
        logic [NDIG-1:0] m;
        logic            z;
        m = '0;
        z = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            z    = z & (b[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction
`endif

    // Control and visible results; outputs load on the final shift so they change only on entering DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            cnt     <= '0;
            Neg     <= 1'b0;
            Bcd     <= '0;
`ifdef PROD_BCD_BLANK_EN
            Blank   <= {{(NDIG-1){1'b1}}, 1'b0};
`endif
        end else begin
            state   <= state_nxt;
            start_q <= Start;
            if (launch)
                cnt <= '0;
            else if (state == SHIFT)
                cnt <= cnt + 1'b1;
            if (last) begin
                Neg   <= neg_i;
                Bcd   <= acc_shl;
`ifdef PROD_BCD_BLANK_EN
                Blank <= blank_mask(acc_shl);
`endif
            end
        end
    end

    // Working datapath; never observed outside a conversion, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (launch) begin
            neg_i <= Prod[PROD_W-1];
            mag   <= Prod[PROD_W-1] ? PROD_W'(-Prod) : PROD_W'(Prod);
            acc   <= '0;
        end else if (state == SHIFT) begin
            mag   <= mag << 1;
            acc   <= acc_shl;
        end
    end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv; Blank checks compile in with PROD_BCD_BLANK_EN.
module tb_product_bcd_conv;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] Prod;
    logic        Busy;
    logic        Done;
    logic        Neg;
    logic [19:0] Bcd;
`ifdef PROD_BCD_BLANK_EN
    logic [4:0]  Blank;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [19:0] prev_bcd;

    product_bcd_conv dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Prod  (Prod),
        .Busy  (Busy),
        .Done  (Done),
        .Neg   (Neg),
        .Bcd   (Bcd)
`ifdef PROD_BCD_BLANK_EN
        ,
        .Blank (Blank)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Full conversion with a one-cycle Start pulse; launch is the first edge.
    task automatic conv(input logic [15:0] p, input logic n, input logic [19:0] b);
        Prod  = p;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("busy_rise", {31'd0, Busy}, 32'd1);
        chk("done_fall", {31'd0, Done}, 32'd0);
        repeat (7) tick();
        chk("hold_bcd", {12'd0, Bcd}, {12'd0, prev_bcd});
        repeat (8) tick();
        chk("busy_last", {31'd0, Busy}, 32'd1);
        tick();
        chk("busy_end", {31'd0, Busy}, 32'd0);
        chk("done_set", {31'd0, Done}, 32'd1);
        chk("neg", {31'd0, Neg}, {31'd0, n});
        chk("bcd", {12'd0, Bcd}, {12'd0, b});
        prev_bcd = b;
    endtask

    initial begin
        Reset    = 1'b0;
        Start    = 1'b0;
        Prod     = 16'h0000;
        prev_bcd = 20'h00000;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_neg", {31'd0, Neg}, 32'd0);
        chk("rst_bcd", {12'd0, Bcd}, 32'd0);
`ifdef PROD_BCD_BLANK_EN
        chk("rst_blank", {27'd0, Blank}, {27'd0, 5'b11110});
`endif
        Reset = 1'b1;
        tick();

        // 0x07 * 0xC5 = -413, then extremes and back-to-back launches
        conv(16'hFE63, 1'b1, 20'h00413);
`ifdef PROD_BCD_BLANK_EN
        chk("blank_413", {27'd0, Blank}, {27'd0, 5'b11000});
`endif
        conv(16'h8000, 1'b1, 20'h32768);
        conv(16'h7FFF, 1'b0, 20'h32767);
        conv(16'h4000, 1'b0, 20'h16384);
        conv(16'h0000, 1'b0, 20'h00000);
`ifdef PROD_BCD_BLANK_EN
        chk("blank_zero", {27'd0, Blank}, {27'd0, 5'b11110});
`endif

        // second Start at cycle 5 of a conversion must be ignored
        Prod  = 16'h0010;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Prod  = 16'h0020;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("ign_busy", {31'd0, Busy}, 32'd1);
        chk("ign_hold", {12'd0, Bcd}, 32'd0);
        repeat (11) tick();
        chk("ign_done", {31'd0, Done}, 32'd1);
        chk("ign_bcd", {12'd0, Bcd}, 32'h00016);
        repeat (3) tick();
        chk("ign_stay", {31'd0, Done}, 32'd1);
        chk("ign_idle", {31'd0, Busy}, 32'd0);

        // asynchronous reset at cycle 8 of a conversion
        Prod  = 16'h1234;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (8) tick();
        Prod  = 16'hFFFF;
        Start = 1'b1;
        Reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_done", {31'd0, Done}, 32'd0);
        chk("arst_neg", {31'd0, Neg}, 32'd0);
        chk("arst_bcd", {12'd0, Bcd}, 32'd0);
`ifdef PROD_BCD_BLANK_EN
        chk("arst_blank", {27'd0, Blank}, {27'd0, 5'b11110});
`endif
        #2;
        Reset = 1'b1;
        tick();
        chk("hi_busy", {31'd0, Busy}, 32'd1);
        repeat (15) tick();
        chk("hi_busy_last", {31'd0, Busy}, 32'd1);
        tick();
        chk("hi_done", {31'd0, Done}, 32'd1);
        chk("hi_neg", {31'd0, Neg}, 32'd1);
        chk("hi_bcd", {12'd0, Bcd}, 32'h00001);
        for (int i = 0; i < 4; i++) begin
            repeat (5) tick();
            chk("hi_done_stay", {31'd0, Done}, 32'd1);
            chk("hi_no_relaunch", {31'd0, Busy}, 32'd0);
        end

        // drop and re-raise Start: second conversion, Done low for 16 cycles
        Start = 1'b0;
        tick();
        Prod  = 16'h0FA0;
        Start = 1'b1;
        tick();
        chk("re_done_low0", {31'd0, Done}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("re_done_low", {31'd0, Done}, 32'd0);
        end
        tick();
        chk("re_done", {31'd0, Done}, 32'd1);
        chk("re_neg", {31'd0, Neg}, 32'd0);
        chk("re_bcd", {12'd0, Bcd}, 32'h04000);
        repeat (10) tick();
        chk("re_done_stay", {31'd0, Done}, 32'd1);
        chk("re_idle", {31'd0, Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_bcd_conv.md
# product_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the 8×8 add-shift `multiplier`. On a start event it captures the signed 16-bit product `{Aval, Bval}` and converts its magnitude to five packed BCD digits plus a sign flag using iterative double-dabble, one bit per clock. The result feeds the decimal hex-display stage, so the operator reads the product in decimal rather than hex.

## Interface
Parameters:
- `PROD_W`, default 16: product width, two's complement.
- `NDIG`, default 5: BCD digit count. Must satisfy 10^NDIG > 2^(PROD_W-1).

Ports:
- `Clk` in 1: system clock, rising-edge.
- `Reset` in 1: reset, asynchronous, active-low.
- `Start` in 1: conversion request; launch is triggered by its rising edge, detected internally.
- `Prod` in PROD_W: signed product, i.e. `{Aval, Bval}`; sampled only on the launch edge.
- `Busy` out 1: conversion in progress.
- `Done` out 1: result valid; level signal, stays high until the next launch.
- `Neg` out 1: sign of the last converted product.
- `Bcd` out NDIG*4: packed digits, digit 0 in [3:0].
- `Blank` out NDIG: leading-zero mask. Present only with the macro (see Configuration).

## Operation
- Edge detect: register `start_q` (reset 0). Launch condition is `Start & ~start_q` while state is IDLE or DONE.
- FSM states IDLE, SHIFT, DONE. Reset state is IDLE.
  - IDLE or DONE, on launch: capture `Neg_i = Prod[PROD_W-1]` and `mag = Neg_i ? -Prod : Prod`, treated as unsigned PROD_W bits (0x8000 → 32768). Clear the BCD accumulator, set count = 0, go to SHIFT.
  - SHIFT, each cycle:
    - for every digit ≥ 5, add 3;
    - shift {accumulator, mag} left by 1;
    - count++;
    - when count reaches PROD_W-1, go to DONE on the same edge.
  - DONE: load the `Bcd`/`Neg` output registers from the internal accumulator and sign. Stay in DONE until the next launch.
- Output registers change only on entering DONE. During SHIFT they hold the previous result, so the display does not flicker.
- Zero product gives Neg = 0 and Bcd = 0.
- A rising `Start` during SHIFT is ignored, not queued. The edge is consumed because `start_q` still tracks `Start`.
- `Start` held high continuously gives exactly one conversion.

## Timing
- Reset values: Busy 0, Done 0, Neg 0, Bcd 0, Blank = all digits except digit 0 set, `start_q` 0, count 0.
- The launch edge is cycle 0. Busy = 1 from after edge 0 through the final shift. Busy = 0 and Done = 1 with valid Bcd/Neg after edge PROD_W (16 by default).
- Done falls after the next launch edge, which is the same edge on which Busy rises.
- Reset asserted mid-conversion: immediate asynchronous return to IDLE with all outputs at reset values. No partial result is visible.
- Back-to-back operation: a launch is accepted in the cycle after Done rises. Throughput is one conversion per PROD_W+1 cycles minimum.

## Configuration
- `PROD_BCD_BLANK_EN` defined:
  - the `Blank` port exists;
  - for i ≥ 1, `Blank[i] = 1` when digit i and all higher digits are 0;
  - `Blank[0]` is always 0;
  - the mask is registered, updated together with `Bcd`.
- Undefined: the `Blank` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `lab5_pkg`:
  - `PROD_W` and `NDIG` default constants;
  - `bcd_state_t` enum {IDLE, SHIFT, DONE};
  - `BCD_CNT_W = $clog2(PROD_W)`.
- Sub-module `bcd_add3`: combinational per-digit correction, 4-bit in/out, adds 3 when the digit is ≥ 5. Instantiated NDIG times by a generate loop.

## Test plan
- Prod = 0xFE63 (0x07 × 0xC5 = −413), Start pulse → after 16 cycles: Done = 1, Neg = 1, Bcd = 0x00413, Blank = 5'b11000.
- Prod = 0x8000 → Neg = 1, Bcd = 0x32768. Prod = 0x7FFF → Neg = 0, Bcd = 0x32767. Prod = 0x4000 → Bcd = 0x16384.
- Prod = 0x0000 → Neg = 0, Bcd = 0x00000, Blank = 5'b11110, Done after 16 cycles.
- Convert 0x0010, then change Prod to 0x0020 and pulse Start at cycle 5 of the conversion → the second Start is ignored, result is 16 (Bcd = 0x00016); during Busy, Bcd holds the prior value.
- Assert Reset at cycle 8 of a conversion → Busy/Done/Neg/Bcd = 0 immediately. Release Reset with Start held high → one conversion only, Done stays high indefinitely.
- Hold Start high through the conversion, drop it, then raise it again → exactly two conversions, with Done deasserting for 16 cycles between them.
